// File: rtl/field_deserializer_6.sv
// ============================================================================
// Module   : field_deserializer_6
// Brief    : Serial-to-parallel field assembler with valid/ready output and
//            registered all-ones / any-one flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module field_deserializer_6 #(
    parameter int WIDTH     = 6,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic [WIDTH-1:0] field_out,
    output logic             field_valid,
    input  logic             field_ready,
    output logic             field_all1,
    output logic             field_any1,
    output logic [2:0]       bit_count
);

    localparam logic [2:0] C_LAST = 3'(WIDTH - 1);

    logic [WIDTH-1:0] r_shift;
    logic [2:0]       r_bit_count;
    logic [WIDTH-1:0] r_field;
    logic             r_valid;
    logic             r_all1;
    logic             r_any1;

    logic             w_last;
    logic             w_ready;
    logic             w_accept;
    logic             w_complete;
    logic [WIDTH-1:0] w_shift_next;

    assign w_last     = (r_bit_count == C_LAST);
    // Only the completing bit can stall, and only while the held field is not leaving.
    assign w_ready    = ~(w_last & r_valid & ~field_ready) & ~clear;
    assign w_accept   = bit_valid & w_ready;
    assign w_complete = w_accept & w_last;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shift_next = {r_shift[WIDTH-2:0], bit_in};
        end else begin : g_lsb_first
            always_comb begin
                w_shift_next              = r_shift;
                w_shift_next[r_bit_count] = bit_in;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift     <= '0;
            r_bit_count <= '0;
            r_field     <= '0;
            r_valid     <= 1'b0;
            r_all1      <= 1'b0;
            r_any1      <= 1'b0;
        end else if (clear) begin
            r_shift     <= '0;
            r_bit_count <= '0;
            r_field     <= '0;
            r_valid     <= 1'b0;
            r_all1      <= 1'b0;
            r_any1      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_shift     <= w_shift_next;
                r_bit_count <= w_last ? 3'd0 : r_bit_count + 3'd1;
            end
            if (w_complete) begin
                r_field <= w_shift_next;
                r_all1  <= &w_shift_next;
                r_any1  <= |w_shift_next;
                r_valid <= 1'b1;
            end else if (r_valid && field_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bit_ready   = w_ready;
    assign field_out   = r_field;
    assign field_valid = r_valid;
    assign field_all1  = r_all1;
    assign field_any1  = r_any1;
    assign bit_count   = r_bit_count;

endmodule

`default_nettype wire
